// File: rtl/line_buffer_ctrl_pkg.sv
// Shared constants, widths and state type for the line buffer sequencer.
// Also provides the read-mask helper used by the controller.
package line_buffer_ctrl_pkg;

    localparam int LINE_WIDTH = 480;
    localparam int KERNEL     = 6;
    localparam int NUM_BUF    = KERNEL + 1;
    localparam int RD_COUNT   = LINE_WIDTH - KERNEL + 1;

    localparam int SEL_W = $clog2(NUM_BUF);
    localparam int PIX_W = $clog2(LINE_WIDTH);
    localparam int OCC_W = $clog2(NUM_BUF * LINE_WIDTH + 1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    // KERNEL consecutive buffers starting at the top row, modulo NUM_BUF
    function automatic logic [NUM_BUF-1:0] read_mask(
        input logic [SEL_W-1:0] sel
    );
        logic [NUM_BUF-1:0] m;
        int idx;
        m = '0;
        for (int k = 0; k < KERNEL; k++) begin
            idx = (int'(sel) + k) % NUM_BUF;
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel-in / window-out control bundle between the sequencer,
// the line buffer bank and the window stage.
interface line_buffer_ctrl_if;
    import line_buffer_ctrl_pkg::*;

    logic               i_pixel_valid;
    logic               o_ready;
    logic [NUM_BUF-1:0] o_lb_wr_en;
    logic               i_out_ready;
    logic [NUM_BUF-1:0] o_lb_rd_en;
    logic [SEL_W-1:0]   o_rd_sel;
    logic               o_window_valid;
    logic               o_line_done;

    modport master (
        input  i_pixel_valid,
        input  i_out_ready,
        output o_ready,
        output o_lb_wr_en,
        output o_lb_rd_en,
        output o_rd_sel,
        output o_window_valid,
        output o_line_done
    );

    modport slave (
        output i_pixel_valid,
        output i_out_ready,
        input  o_ready,
        input  o_lb_wr_en,
        input  o_lb_rd_en,
        input  o_rd_sel,
        input  o_window_valid,
        input  o_line_done
    );

endinterface

// File: rtl/line_buffer_ctrl_mod_counter.sv
// Modulo-MOD up counter with a same-cycle wrap pulse.
// wrap is high on the enabled count that returns to zero.
module mod_counter #(
    parameter int MOD = 2,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Steers pixels into one line buffer at a time and reads KERNEL
// buffers in lock-step, retiring one line per read pass.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    line_buffer_ctrl_if.master bus
);

    localparam logic [OCC_W-1:0] FULL =
        OCC_W'(NUM_BUF * LINE_WIDTH);
    localparam logic [OCC_W-1:0] THRESH =
        OCC_W'(KERNEL * LINE_WIDTH);
    localparam logic [OCC_W-1:0] LW_OCC =
        OCC_W'(LINE_WIDTH);
    localparam logic [NUM_BUF-1:0] ONE =
        {{(NUM_BUF-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_n;
    logic [OCC_W-1:0]   total;
    logic               ready;
    logic               wr;
    logic               rd;
    logic               retire;
    logic               line_done;
    logic [PIX_W-1:0]   wr_pix;
    logic [PIX_W-1:0]   rd_pix;
    logic [SEL_W-1:0]   wr_sel;
    logic [SEL_W-1:0]   rd_sel;
    logic               wr_line;
    logic               wr_sel_wrap;
    logic               rd_sel_wrap;
    logic               unused_wraps;

    assign ready = (total < FULL);
    // Gate with reset so no enable escapes while the bank is cleared
    assign wr = bus.i_pixel_valid & ready & ~i_rst;

    mod_counter #(.MOD(LINE_WIDTH), .W(PIX_W)) u_wr_pix (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (wr),
        .count (wr_pix),
        .wrap  (wr_line)
    );

    mod_counter #(.MOD(NUM_BUF), .W(SEL_W)) u_wr_sel (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (wr_line),
        .count (wr_sel),
        .wrap  (wr_sel_wrap)
    );

    mod_counter #(.MOD(RD_COUNT), .W(PIX_W)) u_rd_pix (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (rd),
        .count (rd_pix),
        .wrap  (retire)
    );

    mod_counter #(.MOD(NUM_BUF), .W(SEL_W)) u_rd_sel (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (retire),
        .count (rd_sel),
        .wrap  (rd_sel_wrap)
    );

    assign unused_wraps = &{1'b0, wr_sel_wrap, rd_sel_wrap};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        rd      = 1'b0;
        unique case (state)
            IDLE: begin
                if (total >= THRESH) begin
                    state_n = READ;
                end
            end
            READ: begin
                rd = bus.i_out_ready;
                if (retire) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            total     <= '0;
            line_done <= 1'b0;
        end else begin
            total     <= total + OCC_W'(wr)
                       - (retire ? LW_OCC : '0);
            line_done <= retire;
        end
    end

    assign bus.o_ready        = ready;
    assign bus.o_lb_wr_en     = wr ? (ONE << wr_sel) : '0;
    assign bus.o_lb_rd_en     = rd ? read_mask(rd_sel) : '0;
    assign bus.o_rd_sel       = rd_sel;
    assign bus.o_window_valid = rd;
    assign bus.o_line_done    = line_done;

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequencer for the bank of NUM_BUF line buffers feeding the Harris window stage. It steers incoming pixels into one buffer at a time. Once KERNEL lines are stored, it reads KERNEL buffers in lock-step, one horizontal window position per cycle, and rotates which buffer is the top row. It retires one line per completed read pass and tracks occupancy so upstream never overwrites a buffer that is being read.

Parameters:
LINE_WIDTH, 480, pixels per line; equals the line buffer depth.
KERNEL, 6, window height and width; also the number of buffers read together.
NUM_BUF, 7, number of line buffers; must equal KERNEL+1.
RD_COUNT, 475, read positions per line; equals LINE_WIDTH-KERNEL+1.

Ports:
i_clk  in  1  clock; all logic is rising-edge.
i_rst  in  1  asynchronous, active-high reset; drive it together with the line buffers' i_rst.
i_pixel_valid  in  1  upstream pixel strobe.
o_ready  out  1  1 while the buffers are not full; upstream must write only while o_ready=1.
o_lb_wr_en  out  NUM_BUF  one-hot write enables, one bit per buffer i_data_valid.
i_out_ready  in  1  downstream window stage accepts a window this cycle.
o_lb_rd_en  out  NUM_BUF  read-advance enables, one bit per buffer i_rd_data.
o_rd_sel  out  clog2(NUM_BUF)  index of the top-row (oldest) buffer, used by the row mux.
o_window_valid  out  1  the current line buffer outputs form a valid window.
o_line_done  out  1  1-cycle pulse when a read pass completes and a line is retired.

Behaviour:
- Reset, asynchronous: all counters = 0, state = IDLE, wr_sel = 0, rd_sel = 0. Outputs: o_lb_wr_en=0, o_lb_rd_en=0, o_window_valid=0, o_line_done=0, o_rd_sel=0, o_ready=1.
- Write side:
  - wr = i_pixel_valid & o_ready.
  - o_lb_wr_en = wr ? (1<<wr_sel) : 0. This is combinational, so the buffer captures the pixel on the same edge.
  - wr_pix counts 0..LINE_WIDTH-1 on each wr. When it wraps to 0, wr_sel advances by 1 mod NUM_BUF.
  - Pixels presented while o_ready=0 are dropped: no enable is raised and no counter changes.
- Occupancy: total is 12 bits, range 0..NUM_BUF*LINE_WIDTH (3360).
  - Increments by 1 on wr.
  - Decrements by LINE_WIDTH on retire.
  - When wr and retire fall in the same cycle, the net change is +1-LINE_WIDTH.
  - o_ready = (total < NUM_BUF*LINE_WIDTH), decoded combinationally from the registered total.
- Read FSM has two states:
  - IDLE -> READ when total >= KERNEL*LINE_WIDTH (2880).
  - READ: rd = i_out_ready. o_window_valid = rd. o_lb_rd_en = rd ? mask : 0.
  - mask has bits (rd_sel+k) mod NUM_BUF set, for k = 0..KERNEL-1.
  - rd_pix counts 0..RD_COUNT-1 on each rd.
  - On the rd with rd_pix = RD_COUNT-1, the FSM retires the line: state -> IDLE, rd_pix -> 0, rd_sel -> (rd_sel+1) mod NUM_BUF, total -= LINE_WIDTH, and o_line_done pulses for 1 cycle (registered).
  - While i_out_ready=0 in READ, the FSM holds: no enables, no counter movement, o_window_valid=0.
- Latency:
  - Window data is valid in the same cycle o_window_valid=1; the buffer read is combinational at its read pointer.
  - READ is entered on the cycle after the threshold is reached.
  - There is always at least 1 IDLE cycle between passes, so a pass takes at least RD_COUNT+1 cycles.
- Invariant: the buffer selected by o_lb_wr_en is never in the read mask while the FSM is in READ. The occupancy bound guarantees this. The bench asserts it.
- Wrap-around: wr_sel and rd_sel wrap from NUM_BUF-1 to 0. Masks wrap modulo NUM_BUF.
- Reset mid-operation: all state clears immediately; no o_line_done pulse is issued for the partial pass.

Decomposition:
- Package line_buffer_ctrl_pkg holds:
  - default constants LINE_WIDTH, KERNEL, NUM_BUF, RD_COUNT;
  - derived widths SEL_W=clog2(NUM_BUF), PIX_W=clog2(LINE_WIDTH), OCC_W=clog2(NUM_BUF*LINE_WIDTH+1);
  - the state enum {IDLE, READ}.
- One sub-module, mod_counter (parameter MOD; enable, wrap pulse output). It is instantiated for wr_pix, wr_sel, rd_pix and rd_sel.

Test Plan:
1. Reset: assert i_rst mid-stream -> all outputs 0 except o_ready=1 in the same cycle, with no clock edge needed; after release, the first pixel gives o_lb_wr_en=7'b0000001.
2. Write steering: 960 consecutive pixels -> o_lb_wr_en=7'b0000001 for pixels 0..479 and 7'b0000010 for 480..959; o_window_valid stays 0.
3. First pass: 2880 pixels with i_out_ready=1 -> next cycle o_lb_rd_en=7'b0111111, o_rd_sel=0, o_window_valid high for 475 cycles, then one o_line_done pulse; total drops to 2880 minus 480 plus the writes made during the pass.
4. Full / backpressure: i_out_ready=0 after READ is entered, 3360 pixels pushed -> o_ready=0 after pixel 3360 and pixel 3361 is dropped; raising i_out_ready -> 475 windows, retire, then o_ready=1.
5. Rotation wrap: stream 10 lines with continuous i_out_ready -> o_rd_sel steps 0,1,2,3,4; at o_rd_sel=3 the read mask is 7'b1111011; the write-not-in-mask assertion never fires.
6. Stall mid-pass: toggle i_out_ready 1/0 each cycle -> exactly 475 o_window_valid cycles per pass, and o_lb_rd_en=0 on every stalled cycle.
